// File: rtl/pwm_duty_ramp.sv
// pwm_duty_ramp: double-buffers the CPU-written period and duty onto the
// PWM comparator inputs. Updates happen only on PWM period boundaries. The
// duty walks toward its target by a fixed step once per period, which gives
// a soft fade-in and fade-out.
module pwm_duty_ramp #(
    parameter int WIDTH        = 28,
    parameter int STEP_W       = 16,
    parameter int RESET_PERIOD = 1000
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [WIDTH-1:0]  PERIOD_IN,
    input  logic [WIDTH-1:0]  TARGET_IN,
    input  logic [STEP_W-1:0] STEP_IN,
    input  logic              ENABLE,
    input  logic              PERIOD_END,
    output logic [WIDTH-1:0]  PERIOD_OUT,
    output logic [WIDTH-1:0]  DECODE_OUT,
    output logic              BUSY,
    output logic              DONE
);

    // One extra bit of headroom, so that D + S can never wrap even when the
    // step is as wide as the duty.
    localparam int EXT_W = ((WIDTH > STEP_W) ? WIDTH : STEP_W) + 1;

    typedef enum logic [1:0] {
        IDLE,
        UP,
        DOWN
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   period_q, period_d;
    logic [WIDTH-1:0]   decode_q, decode_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   tEff;
    logic [WIDTH-1:0]   dEff;
    logic [WIDTH-1:0]   stepDuty;
    logic [EXT_W-1:0]   tExt, dExt, sExt;

    // Form the effective target and the effective current duty. A disabled
    // output targets 0, and a shrinking period clamps both values at once.
    always_comb begin
        tEff = '0;
        if (ENABLE) begin
            tEff = (TARGET_IN < PERIOD_IN) ? TARGET_IN : PERIOD_IN;
        end
        dEff = (decode_q < PERIOD_IN) ? decode_q : PERIOD_IN;
        tExt = EXT_W'(tEff);
        dExt = EXT_W'(dEff);
        sExt = EXT_W'(STEP_IN);
    end

    // Compute one ramp step toward the target. When the remaining distance is
    // no larger than the step, the step lands exactly on the target. A step
    // of 0 jumps straight to the target.
    always_comb begin
        stepDuty = tEff;
        if (sExt != '0) begin
            if (dExt < tExt) begin
                if ((tExt - dExt) > sExt) begin
                    stepDuty = WIDTH'(dExt + sExt);
                end
            end else if (dExt > tExt) begin
                if ((dExt - tExt) > sExt) begin
                    stepDuty = WIDTH'(dExt - sExt);
                end
            end
        end
    end

    // Compute the next state and outputs. Everything holds between period
    // boundaries, and DONE falls back to 0. At a boundary, the direction is
    // re-derived from the new duty, so a retarget can flip UP to DOWN.
    always_comb begin
        period_d = period_q;
        decode_d = decode_q;
        state_d  = state_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        if (PERIOD_END) begin
            period_d = PERIOD_IN;
            decode_d = stepDuty;
            if (stepDuty == tEff) begin
                state_d = IDLE;
            end else if (stepDuty < tEff) begin
                state_d = UP;
            end else begin
                state_d = DOWN;
            end
            busy_d = (state_d != IDLE);
            done_d = (state_q != IDLE) && (state_d == IDLE);
        end
    end

    // Hold the shadowed values and the ramp state. Reset drops everything
    // back to idle, so an interrupted ramp does not resume.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            period_q <= WIDTH'(RESET_PERIOD);
            decode_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            decode_q <= decode_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign PERIOD_OUT = period_q;
    assign DECODE_OUT = decode_q;
    assign BUSY       = busy_q;
    assign DONE       = done_q;

endmodule
